// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding, data-width limits and parity helper
package uart_pkg;

    localparam int UART_MIN_DATA_BITS = 5;
    localparam int UART_MAX_DATA_BITS = 9;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK_WAIT
    } uart_rx_state_t;

    // Parity bit a transmitter puts on the line; unused upper bits must be zero.
    function automatic logic uart_parity(input logic [UART_MAX_DATA_BITS-1:0] data,
                                         input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchronizer for the serial line, resets to idle-high
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// rtl/uart_rx_os.sv - oversampling UART receiver; parity bit compiled in with UART_RX_PARITY_EN
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 7,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 break_det
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(UART_MAX_DATA_BITS);
    localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] WRAP = CW'(CLKS_PER_BIT - 1);

    if (DATA_BITS < UART_MIN_DATA_BITS || DATA_BITS > UART_MAX_DATA_BITS ||
        STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1 ||
        CLKS_PER_BIT < 4) begin : g_cfg_err
        $error("uart_rx_os: unsupported parameter combination");
    end

    uart_rx_state_t       state, state_n;
    logic                 rxd_s;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_idx;
    logic                 stop_idx;
    logic                 stop_err;
    logic [DATA_BITS-1:0] sh;
    logic                 mid;
    logic                 frame_done;
    logic                 brk_hit;
    logic                 frame_fe;
    logic                 frame_pe;
    logic                 par_zero;

    uart_rx_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (rxd_s)
    );

`ifdef UART_RX_PARITY_EN
    localparam uart_rx_state_t AFTER_DATA = PARITY;
    logic                          par_bit;
    logic [UART_MAX_DATA_BITS-1:0] sh_ext;

    always_comb begin
        sh_ext                = '0;
        sh_ext[DATA_BITS-1:0] = sh;
    end

    assign frame_pe = par_bit ^ uart_parity(sh_ext, 1'(PARITY_ODD));
    assign par_zero = ~par_bit;
`else
    localparam uart_rx_state_t AFTER_DATA = STOP;
    assign frame_pe = 1'b0;
    assign par_zero = 1'b1;
`endif

    assign mid      = (cnt == MID);
    assign frame_fe = brk_hit | stop_err | ~rxd_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n    = state;
        frame_done = 1'b0;
        brk_hit    = 1'b0;
        case (state)
            IDLE:       if (!rxd_s) state_n = START;
            START:      if (mid) state_n = rxd_s ? IDLE : DATA;
            DATA:       if (mid && bit_idx == BW'(DATA_BITS - 1)) state_n = AFTER_DATA;
            PARITY:     if (mid) state_n = STOP;
            STOP: begin
                // A break is recognised on the first stop sample so the line can stay low indefinitely.
                if (mid) begin
                    if (!stop_idx && !rxd_s && sh == '0 && par_zero) begin
                        brk_hit    = 1'b1;
                        frame_done = 1'b1;
                        state_n    = BREAK_WAIT;
                    end else if (stop_idx == 1'(STOP_BITS - 1)) begin
                        frame_done = 1'b1;
                        state_n    = IDLE;
                    end
                end
            end
            BREAK_WAIT: if (rxd_s) state_n = IDLE;
            default:    state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            stop_err <= 1'b0;
            sh       <= '0;
`ifdef UART_RX_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else begin
            cnt <= (state == IDLE || cnt == WRAP) ? '0 : cnt + CW'(1);
            case (state)
                START: begin
                    bit_idx  <= '0;
                    stop_idx <= 1'b0;
                    stop_err <= 1'b0;
                end
                DATA: if (mid) begin
                    sh      <= {rxd_s, sh[DATA_BITS-1:1]};
                    bit_idx <= bit_idx + BW'(1);
                end
`ifdef UART_RX_PARITY_EN
                PARITY: if (mid) par_bit <= rxd_s;
`endif
                STOP: if (mid) begin
                    stop_idx <= stop_idx + 1'b1;
                    stop_err <= stop_err | ~rxd_s;
                end
                default: ;
            endcase
        end
    end

    // A held, unaccepted frame wins over a newly completed one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data       <= '0;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
            break_det  <= 1'b0;
        end else begin
            overrun   <= 1'b0;
            break_det <= 1'b0;
            if (frame_done) begin
                break_det <= brk_hit;
                if (valid && !ready) begin
                    overrun <= 1'b1;
                end else begin
                    data       <= brk_hit ? '0 : sh;
                    frame_err  <= frame_fe;
                    parity_err <= frame_pe;
                    valid      <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule
